// File: rtl/apple1_pkg.sv
// -----------------------------------------------------------------------------
// apple1_pkg
// Shared constants for the Apple-1 keyboard port pair at 0xD010 (KBD) and
// 0xD011 (KBDCR), and a small helper used by the keyboard type-ahead FIFO.
//
// Contents:
//   KBD_OFS / KBDCR_OFS   register offsets selected by the CPU address bit
//   KBDCR_*_BIT           status bit positions in KBDCR
//   KBD_STROBE_BIT        "new key" strobe bit in KBD
//   ascii_t               7-bit character type
//   rd_kind_e             decoded CPU-side access for the current cycle
//   fold_upper()          lower-case to upper-case ASCII folding
// -----------------------------------------------------------------------------
package apple1_pkg;

  localparam logic KBD_OFS   = 1'b0;
  localparam logic KBDCR_OFS = 1'b1;

  localparam int KBDCR_RDY_BIT  = 7;
  localparam int KBDCR_OVF_BIT  = 6;
  localparam int KBD_STROBE_BIT = 7;

  localparam int ASCII_W = 7;
  localparam int DATA_W  = 8;

  typedef logic [ASCII_W-1:0] ascii_t;

  // What the CPU is doing to the port pair in this cycle.
  typedef enum logic [1:0] {
    RD_NONE  = 2'd0,
    RD_KBD   = 2'd1,
    RD_KBDCR = 2'd2
  } rd_kind_e;

  // 'a'..'z' map to 'A'..'Z'; every other code passes unchanged.
  // The Apple-1 character ROM only has upper-case glyphs.
  function automatic ascii_t fold_upper(input ascii_t c);
    ascii_t r;
    r = c;
    if (c >= 7'h61 && c <= 7'h7A) begin
      r = c - 7'h20;
    end
    return r;
  endfunction

endpackage

// File: rtl/apple1_fifo_ram.sv
// -----------------------------------------------------------------------------
// apple1_fifo_ram
// DEPTH x WIDTH storage for the keyboard type-ahead FIFO. Registered write
// port, asynchronous read port. Holds no control logic: pointers, occupancy
// and flags live in the parent.
//
// Ports:
//   clk      in   clock for the write port
//   wr_en    in   write strobe
//   wr_addr  in   AW-bit write address
//   wr_data  in   WIDTH-bit write data
//   rd_addr  in   AW-bit read address
//   rd_data  out  WIDTH-bit read data, combinational from rd_addr
// -----------------------------------------------------------------------------
module apple1_fifo_ram #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 7,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  // Contents are never reset; the parent's count decides what is valid.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read: the head character is available in the same cycle the
  // CPU read is decoded, so the parent can register it straight into dout.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/apple1_kbd_fifo.sv
// -----------------------------------------------------------------------------
// apple1_kbd_fifo
// Keyboard type-ahead buffer between the PS/2 scan-code decoder and the 6502
// keyboard port pair (KBD at 0xD010, KBDCR at 0xD011). Characters from the
// decoder are queued; the CPU sees PIA-like semantics with dout registered one
// enabled cycle after the read.
//
// Build option: define KBD_FIFO_UPCASE_EN to fold 'a'..'z' to 'A'..'Z' on push.
// Without it characters are stored exactly as received.
//
// Ports:
//   sys_clock  in   system clock (single domain)
//   reset_n    in   asynchronous active-low reset
//   key_valid  in   one-cycle strobe, key_ascii holds a new character
//   key_ascii  in   7-bit ASCII code
//   cpu_clken  in   CPU clock enable; qualifies every CPU-side action
//   cs         in   chip select for 0xD010-0xD011
//   address    in   0 = KBD, 1 = KBDCR
//   we         in   CPU write (ignored, writes have no effect)
//   dout       out  registered read data
//   count      out  occupancy, 0..DEPTH
//   full       out  count == DEPTH
// -----------------------------------------------------------------------------
module apple1_kbd_fifo
  import apple1_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              sys_clock,
  input  logic              reset_n,
  input  logic              key_valid,
  input  logic [6:0]        key_ascii,
  input  logic              cpu_clken,
  input  logic              cs,
  input  logic              address,
  input  logic              we,
  output logic [7:0]        dout,
  output logic [AW:0]       count,
  output logic              full
);

  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q,  count_d;
  logic              ovf_q,    ovf_d;
  logic [DATA_W-1:0] dout_q,   dout_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  rd_kind_e rd_kind;
  ascii_t   head;
  ascii_t   push_char;
  logic     empty;
  logic     is_full;
  logic     pop;
  logic     push_ok;
  logic     ovf_set;
  logic     ovf_clr;

  assign empty   = (count_q == '0);
  assign is_full = (count_q == FULL_COUNT);

  // Decode the CPU access. Writes and disabled cycles are no-ops.
  always_comb begin
    rd_kind = RD_NONE;
    if (cs && cpu_clken && !we) begin
      rd_kind = (address == KBDCR_OFS) ? RD_KBDCR : RD_KBD;
    end
  end

`ifdef KBD_FIFO_UPCASE_EN
  assign push_char = fold_upper(key_ascii);
`else
  assign push_char = key_ascii;
`endif

  // A pop needs something to pop. Because full implies non-empty, a push into
  // a full FIFO is accepted exactly when a KBD read frees a slot this cycle.
  // On an empty FIFO the read cannot pop, so the new character is simply
  // stored and shows up on the following read (no bypass path).
  assign pop     = (rd_kind == RD_KBD) && !empty;
  assign push_ok = key_valid && (!is_full || pop);
  assign ovf_set = key_valid && !push_ok;
  assign ovf_clr = (rd_kind == RD_KBDCR);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // A dropped character in the same cycle as a KBDCR read keeps the flag set,
  // so the CPU never misses an overflow that raced with its status read.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end
  end

  // dout only changes on a read event and holds its value otherwise.
  always_comb begin
    dout_d = dout_q;
    case (rd_kind)
      RD_KBD: begin
        dout_d = '0;
        if (!empty) begin
          dout_d[KBD_STROBE_BIT] = 1'b1;
          dout_d[ASCII_W-1:0]    = head;
        end
      end
      RD_KBDCR: begin
        dout_d                = '0;
        dout_d[KBDCR_RDY_BIT] = !empty;
        dout_d[KBDCR_OVF_BIT] = ovf_q;
      end
      default: dout_d = dout_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      dout_q   <= dout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  apple1_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ASCII_W)
  ) u_ram (
    .clk     (sys_clock),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (push_char),
    .rd_addr (rd_ptr_q),
    .rd_data (head)
  );

  assign dout  = dout_q;
  assign count = count_q;
  assign full  = is_full;

endmodule

// File: tb/tb_apple1_kbd_fifo.sv
// -----------------------------------------------------------------------------
// tb_apple1_kbd_fifo
// Self-checking bench for apple1_kbd_fifo. A queue-based reference model
// predicts each read response and pushes it to a scoreboard; a monitor on the
// falling edge pops and compares dout, and also compares count/full against
// the model. Directed scenarios add fixed expected values on top.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apple1_kbd_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          sys_clock = 1'b0;
  logic          reset_n   = 1'b0;
  logic          key_valid = 1'b0;
  logic [6:0]    key_ascii = '0;
  logic          cpu_clken = 1'b0;
  logic          cs        = 1'b0;
  logic          address   = 1'b0;
  logic          we        = 1'b0;
  logic [7:0]    dout;
  logic [AW:0]   count;
  logic          full;

  int checks   = 0;
  int failures = 0;

  apple1_kbd_fifo #(.DEPTH(DEPTH)) dut (
    .sys_clock (sys_clock),
    .reset_n   (reset_n),
    .key_valid (key_valid),
    .key_ascii (key_ascii),
    .cpu_clken (cpu_clken),
    .cs        (cs),
    .address   (address),
    .we        (we),
    .dout      (dout),
    .count     (count),
    .full      (full)
  );

  always #5 sys_clock = ~sys_clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a plain queue of characters plus a sticky overflow bit.
  // ---------------------------------------------------------------------------
  logic [6:0] model_q[$];
  logic       model_ovf = 1'b0;
  logic [7:0] exp_q[$];

  function automatic logic [6:0] model_fold(input logic [6:0] c);
`ifdef KBD_FIFO_UPCASE_EN
    if (c >= 7'h61 && c <= 7'h7A) return c - 7'h20;
`endif
    return c;
  endfunction

  always @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      model_q.delete();
      exp_q.delete();
      model_ovf = 1'b0;
    end else begin
      if (cs && cpu_clken && !we) begin
        if (!address) begin
          if (model_q.size() > 0) begin
            exp_q.push_back({1'b1, model_q.pop_front()});
          end else begin
            exp_q.push_back(8'h00);
          end
        end else begin
          exp_q.push_back({(model_q.size() > 0), model_ovf, 6'b0});
          model_ovf = 1'b0;
        end
      end
      // The pop (if any) already happened above, so room exists here exactly
      // when the FIFO was not full or a slot was freed this cycle.
      if (key_valid) begin
        if (model_q.size() < DEPTH) model_q.push_back(model_fold(key_ascii));
        else                        model_ovf = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: one pop per read response, otherwise dout must hold.
  // ---------------------------------------------------------------------------
  logic [7:0] dout_hold = 8'h00;
  int         rd_num    = 0;

  always @(negedge sys_clock) begin
    if (!reset_n) begin
      dout_hold = 8'h00;
      chk("reset_dout", dout, 8'h00);
    end else if (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      rd_num++;
      $display("read %0d dout=%02h exp=%02h count=%0d", rd_num, dout, e, count);
      chk("sb_dout", dout, e);
      dout_hold = e;
    end else begin
      chk("hold_dout", dout, dout_hold);
    end
    chk("model_count", count, model_q.size());
    chk("model_full", full, (model_q.size() == DEPTH));
  end

  // ---------------------------------------------------------------------------
  // Driver: inputs set before a rising edge, cleared 1ns after it.
  // ---------------------------------------------------------------------------
  task automatic drive(input logic kv, input logic [6:0] ka, input logic ce,
                       input logic c, input logic a, input logic w);
    key_valid = kv; key_ascii = ka; cpu_clken = ce; cs = c; address = a; we = w;
    @(posedge sys_clock);
    #1;
    key_valid = 1'b0; cpu_clken = 1'b0; cs = 1'b0; address = 1'b0; we = 1'b0;
  endtask

  task automatic push(input logic [6:0] ka);
    drive(1'b1, ka, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic a);
    drive(1'b0, 7'h00, 1'b1, 1'b1, a, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge sys_clock);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_full", full, 1'b0);
    repeat (2) @(posedge sys_clock);
    @(negedge sys_clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] exp_fold;
    // Reset
    repeat (3) @(posedge sys_clock);
    #1;
    chk("init_dout", dout, 8'h00);
    chk("init_count", count, 0);
    chk("init_full", full, 1'b0);
    @(negedge sys_clock);
    reset_n = 1'b1;

    // Single key
    push(7'h41);
    chk("single_count1", count, 1);
    rd(1'b1); chk("single_kbdcr", dout, 8'h80);
    rd(1'b0); chk("single_kbd", dout, 8'hC1);
    chk("single_count0", count, 0);

    // Empty read
    rd(1'b0); chk("empty_kbd", dout, 8'h00);
    chk("empty_count", count, 0);

    // Fill and overflow
    for (int i = 0; i <= DEPTH; i++) push(7'(8'h30 + i));
    chk("fill_full", full, 1'b1);
    chk("fill_count", count, DEPTH);
    rd(1'b1); chk("fill_kbdcr_ovf", dout, 8'hC0);
    rd(1'b1); chk("fill_kbdcr_clr", dout, 8'h80);
    for (int i = 0; i < DEPTH; i++) begin
      rd(1'b0); chk("fill_drain", dout, 8'hB0 + 8'(i));
    end
    rd(1'b0); chk("fill_17th_absent", dout, 8'h00);

    // Simultaneous push and pop on a full FIFO
    for (int i = 0; i < DEPTH; i++) push(7'(8'h40 + i));
    drive(1'b1, 7'h50, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("simfull_dout", dout, 8'hC0);
    chk("simfull_count", count, DEPTH);
    rd(1'b1); chk("simfull_no_ovf", dout, 8'h80);
    for (int i = 1; i <= DEPTH; i++) begin
      rd(1'b0); chk("simfull_drain", dout, 8'hC0 + 8'(i));
    end

    // Simultaneous push and read on an empty FIFO
    drive(1'b1, 7'h42, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("simempty_dout", dout, 8'h00);
    chk("simempty_count", count, 1);
    rd(1'b0); chk("simempty_next", dout, 8'hC2);

    // cpu_clken low blocks pop and dout update; writes are ignored
    push(7'h33);
    drive(1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("clken_low_dout", dout, 8'hC2);
    chk("clken_low_count", count, 1);
    drive(1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("write_ignored", count, 1);
    rd(1'b0); chk("after_clken", dout, 8'hB3);

    // Case folding
    push(7'h61);
    rd(1'b0);
`ifdef KBD_FIFO_UPCASE_EN
    exp_fold = 8'hC1;
`else
    exp_fold = 8'hE1;
`endif
    chk("case_fold", dout, exp_fold);

    // Reset mid-operation
    push(7'h31); push(7'h32); push(7'h33);
    chk("pre_reset_count", count, 3);
    do_reset();
    rd(1'b1); chk("post_reset_kbdcr", dout, 8'h00);

    // Randomized traffic, alternating push-heavy and read-heavy phases
    for (int n = 0; n < 3000; n++) begin
      int pk;
      pk = ((n / 300) % 2 == 0) ? 70 : 20;
      drive(($urandom_range(0, 99) < pk),
            7'($urandom_range(0, 127)),
            ($urandom_range(0, 99) < 70),
            ($urandom_range(0, 99) < 45),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < 15));
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    repeat (3) @(posedge sys_clock);
    @(negedge sys_clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
